// File: rtl/ss_rmw.sv
// ss_rmw: store-size sequencer. Executes SB/SH/SW into data memory.
// Word stores write directly; byte and halfword stores read the target
// word first and merge the new low bits so the upper bits survive.
// All outputs are driven straight from registers.
module ss_rmw (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  SSControl,
  input  logic [31:0] addr,
  input  logic [31:0] RegBOut,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] b_q, b_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  size_q, size_d;

  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Merge the register value into the old memory word according to size.
  function automatic logic [31:0] merge_store(input logic [1:0]  size,
                                              input logic [31:0] word,
                                              input logic [31:0] bval);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = {word[31:8], bval[7:0]};
      SZ_HALF: res = {word[31:16], bval[15:0]};
      SZ_WORD: res = bval;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // State and latched-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0000_0000;
      b_q     <= 32'h0000_0000;
      word_q  <= 32'h0000_0000;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      b_q     <= b_d;
      word_q  <= word_d;
      size_q  <= size_d;
    end
  end

  // Next-state logic; request fields are captured only on acceptance.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    b_d     = b_q;
    word_d  = word_q;
    size_d  = size_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = addr;
          b_d    = RegBOut;
          size_d = SSControl;
          case (SSControl)
            SZ_WORD:          state_d = S_WRITE;
            SZ_BYTE, SZ_HALF: state_d = S_READ;
            default:          state_d = S_DONE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        word_d  = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is registered.
  always_comb begin
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = 32'h0000_0000;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_d)
      S_READ: begin
        rd_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_WAIT: begin
        busy_d = 1'b1;
      end
      S_WRITE: begin
        wr_d    = 1'b1;
        busy_d  = 1'b1;
        wdata_d = merge_store(size_d, word_d, b_d);
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = (size_d == 2'b11);
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears them immediately, cancelling any write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 32'h0000_0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
